// File: rtl/cv32e40p_apu_arbiter.sv
// APU field widths shared by the core-side and FPU-side interfaces.
package cv32e40p_apu_core_pkg;
  parameter int APU_NARGS_CPU    = 3;
  parameter int APU_WOP_CPU      = 6;
  parameter int APU_NDSFLAGS_CPU = 15;
  parameter int APU_NUSFLAGS_CPU = 5;
endpackage

// Two-core round-robin arbiter in front of one shared FPU.
// A 1-bit ID FIFO records which core owns each outstanding operation
// so that in-order FPU responses can be steered back to the right core.
module cv32e40p_apu_arbiter #(
  parameter int DEPTH            = 4,
  parameter int APU_NARGS_CPU    = cv32e40p_apu_core_pkg::APU_NARGS_CPU,
  parameter int APU_WOP_CPU      = cv32e40p_apu_core_pkg::APU_WOP_CPU,
  parameter int APU_NDSFLAGS_CPU = cv32e40p_apu_core_pkg::APU_NDSFLAGS_CPU,
  parameter int APU_NUSFLAGS_CPU = cv32e40p_apu_core_pkg::APU_NUSFLAGS_CPU
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [1:0]                                 c_req_i,
  output logic [1:0]                                 c_gnt_o,
  input  logic [1:0][APU_NARGS_CPU-1:0][31:0]        c_operands_i,
  input  logic [1:0][APU_WOP_CPU-1:0]                c_op_i,
  input  logic [1:0][APU_NDSFLAGS_CPU-1:0]           c_flags_i,
  output logic [1:0]                                 c_rvalid_o,
  output logic [31:0]                                c_rdata_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                c_rflags_o,
  output logic                                       apu_req_o,
  input  logic                                       apu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]             apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                     apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                apu_flags_o,
  input  logic                                       apu_rvalid_i,
  input  logic [31:0]                                apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                apu_rflags_i,
  output logic                                       fpu_clk_en_o,
  output logic                                       busy_o,
  output logic                                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lockState_t;

  lockState_t       r_lockState;
  lockState_t       w_lockStateNext;
  logic             r_lockCore;
  logic             w_lockCoreNext;
  logic             w_lockDrop;

  logic             r_prio;
  logic             r_err;

  logic [DEPTH-1:0] r_idFifo;
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic             w_sel;
  logic             w_anyReq;
  logic             w_full;
  logic             w_empty;
  logic             w_handshake;
  logic             w_push;
  logic             w_pop;
  logic             w_spurious;
  logic             w_head;

  // Pick the core to present to the FPU: a held lock wins, otherwise round-robin.
  always_comb begin
    w_sel    = 1'b0;
    w_anyReq = 1'b0;
    if (r_lockState == LOCK_HELD) begin
      w_sel    = r_lockCore;
      w_anyReq = c_req_i[r_lockCore];
    end else begin
      w_anyReq = |c_req_i;
      case (c_req_i)
        2'b11:   w_sel = r_prio;
        2'b10:   w_sel = 1'b1;
        default: w_sel = 1'b0;
      endcase
    end
  end

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign apu_req_o   = w_anyReq & ~w_full;
  assign w_handshake = apu_req_o & apu_gnt_i;
  assign w_push      = w_handshake;
  assign w_pop       = apu_rvalid_i & ~w_empty;
  assign w_spurious  = apu_rvalid_i & w_empty;
  assign w_head      = r_idFifo[r_rdPtr];

  assign c_gnt_o        = {w_handshake & w_sel, w_handshake & ~w_sel};
  assign apu_operands_o = c_operands_i[w_sel];
  assign apu_op_o       = c_op_i[w_sel];
  assign apu_flags_o    = c_flags_i[w_sel];

  assign c_rvalid_o   = {w_pop & w_head, w_pop & ~w_head};
  assign c_rdata_o    = apu_rdata_i;
  assign c_rflags_o   = apu_rflags_i;
  assign busy_o       = ~w_empty;
  assign fpu_clk_en_o = (|c_req_i) | busy_o;
  assign err_o        = r_err;

  // Lock next-state: hold an ungranted selection until it is accepted or abandoned.
  always_comb begin
    w_lockStateNext = r_lockState;
    w_lockCoreNext  = r_lockCore;
    w_lockDrop      = 1'b0;
    case (r_lockState)
      LOCK_IDLE: begin
        if (apu_req_o && !apu_gnt_i) begin
          w_lockStateNext = LOCK_HELD;
          w_lockCoreNext  = w_sel;
        end
      end
      LOCK_HELD: begin
        if (w_handshake) begin
          w_lockStateNext = LOCK_IDLE;
        end else if (!c_req_i[r_lockCore]) begin
          w_lockStateNext = LOCK_IDLE;
          w_lockDrop      = 1'b1;
        end
      end
      default: begin
        w_lockStateNext = LOCK_IDLE;
      end
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lockState <= LOCK_IDLE;
      r_lockCore  <= 1'b0;
    end else begin
      r_lockState <= w_lockStateNext;
      r_lockCore  <= w_lockCoreNext;
    end
  end

  // Priority moves to the core that lost the most recent accepted handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio <= 1'b0;
    end else if (w_handshake) begin
      r_prio <= ~w_sel;
    end
  end

  // Sticky protocol error: abandoned lock or response with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_spurious || w_lockDrop) begin
      r_err <= 1'b1;
    end
  end

  // ID FIFO storage and pointers; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idFifo <= '0;
      r_wrPtr  <= '0;
      r_rdPtr  <= '0;
    end else begin
      if (w_push) begin
        r_idFifo[r_wrPtr] <= w_sel;
        r_wrPtr           <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Self-checking bench for cv32e40p_apu_arbiter: directed scenarios followed
// by a randomized run, all compared against a queue-based reference model.
module tb_cv32e40p_apu_arbiter;

  localparam int DEPTH = 4;
  localparam int NARGS = cv32e40p_apu_core_pkg::APU_NARGS_CPU;
  localparam int WOP   = cv32e40p_apu_core_pkg::APU_WOP_CPU;
  localparam int NDS   = cv32e40p_apu_core_pkg::APU_NDSFLAGS_CPU;
  localparam int NUS   = cv32e40p_apu_core_pkg::APU_NUSFLAGS_CPU;

  logic                         clk;
  logic                         rst;
  logic [1:0]                   cReq;
  logic [1:0]                   cGnt;
  logic [1:0][NARGS-1:0][31:0]  cOperands;
  logic [1:0][WOP-1:0]          cOp;
  logic [1:0][NDS-1:0]          cFlags;
  logic [1:0]                   cRvalid;
  logic [31:0]                  cRdata;
  logic [NUS-1:0]               cRflags;
  logic                         apuReq;
  logic                         apuGnt;
  logic [NARGS-1:0][31:0]       apuOperands;
  logic [WOP-1:0]               apuOp;
  logic [NDS-1:0]               apuFlags;
  logic                         apuRvalid;
  logic [31:0]                  apuRdata;
  logic [NUS-1:0]               apuRflags;
  logic                         fpuClkEn;
  logic                         busy;
  logic                         err;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model: outstanding owners in order, priority core, locked core (-1 = none), error flag.
  int idQ[$];
  int mPrio;
  int mLock;
  bit mErr;

  // Observations from the most recent applyStimulus cycle, for scenario-level checks.
  logic [1:0]     lastGnt;
  logic [1:0]     lastRvalid;
  logic           lastReq;
  logic [WOP-1:0] lastOp;
  logic [WOP-1:0] drvOp1;
  logic           lastErr;
  logic           lastBusy;
  logic           lastClkEn;

  cv32e40p_apu_arbiter #(
    .DEPTH            (DEPTH),
    .APU_NARGS_CPU    (NARGS),
    .APU_WOP_CPU      (WOP),
    .APU_NDSFLAGS_CPU (NDS),
    .APU_NUSFLAGS_CPU (NUS)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .c_req_i        (cReq),
    .c_gnt_o        (cGnt),
    .c_operands_i   (cOperands),
    .c_op_i         (cOp),
    .c_flags_i      (cFlags),
    .c_rvalid_o     (cRvalid),
    .c_rdata_o      (cRdata),
    .c_rflags_o     (cRflags),
    .apu_req_o      (apuReq),
    .apu_gnt_i      (apuGnt),
    .apu_operands_o (apuOperands),
    .apu_op_o       (apuOp),
    .apu_flags_o    (apuFlags),
    .apu_rvalid_i   (apuRvalid),
    .apu_rdata_i    (apuRdata),
    .apu_rflags_i   (apuRflags),
    .fpu_clk_en_o   (fpuClkEn),
    .busy_o         (busy),
    .err_o          (err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    idQ.delete();
    mPrio = 0;
    mLock = -1;
    mErr  = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic resetDut();
    cReq      = 2'b00;
    apuGnt    = 1'b0;
    apuRvalid = 1'b0;
    rst       = 1'b1;
    #1;
    checkOutput("rst_busy",   128'(busy),     128'(0));
    checkOutput("rst_clkEn",  128'(fpuClkEn), 128'(0));
    checkOutput("rst_apuReq", 128'(apuReq),   128'(0));
    checkOutput("rst_gnt",    128'(cGnt),     128'(0));
    checkOutput("rst_err",    128'(err),      128'(0));
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs, check every output at the falling edge, advance the model.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv);
    logic [31:0]            tmp;
    int                     sel;
    bit                     anyReq;
    bit                     expReq;
    bit                     hs;
    logic [1:0]             expGnt;
    logic [1:0]             expRvalid;
    cReq      = req;
    apuGnt    = gnt;
    apuRvalid = rv;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < NARGS; a++) cOperands[k][a] = $urandom;
      tmp = $urandom;
      cOp[k] = tmp[WOP-1:0];
      tmp = $urandom;
      cFlags[k] = tmp[NDS-1:0];
    end
    apuRdata  = $urandom;
    tmp       = $urandom;
    apuRflags = tmp[NUS-1:0];
    drvOp1    = cOp[1];

    if (mLock >= 0) begin
      sel    = mLock;
      anyReq = req[mLock];
    end else begin
      anyReq = (req != 2'b00);
      if (req == 2'b11) sel = mPrio;
      else if (req == 2'b10) sel = 1;
      else sel = 0;
    end
    expReq    = anyReq && (idQ.size() < DEPTH);
    hs        = expReq && gnt;
    expGnt    = hs ? ((sel == 1) ? 2'b10 : 2'b01) : 2'b00;
    expRvalid = (rv && idQ.size() > 0) ? ((idQ[0] == 1) ? 2'b10 : 2'b01) : 2'b00;

    @(negedge clk);
    checkOutput("apuReq",  128'(apuReq),   128'(expReq));
    checkOutput("cGnt",    128'(cGnt),     128'(expGnt));
    checkOutput("cRvalid", 128'(cRvalid),  128'(expRvalid));
    checkOutput("cRdata",  128'(cRdata),   128'(apuRdata));
    checkOutput("cRflags", 128'(cRflags),  128'(apuRflags));
    checkOutput("busy",    128'(busy),     128'(idQ.size() != 0));
    checkOutput("clkEn",   128'(fpuClkEn), 128'((req != 2'b00) || (idQ.size() != 0)));
    checkOutput("err",     128'(err),      128'(mErr));
    if (expReq) begin
      checkOutput("apuOperands", 128'(apuOperands), 128'(cOperands[sel]));
      checkOutput("apuOp",       128'(apuOp),       128'(cOp[sel]));
      checkOutput("apuFlags",    128'(apuFlags),    128'(cFlags[sel]));
    end
    lastGnt    = cGnt;
    lastRvalid = cRvalid;
    lastReq    = apuReq;
    lastOp     = apuOp;
    lastErr    = err;
    lastBusy   = busy;
    lastClkEn  = fpuClkEn;

    if (rv) begin
      if (idQ.size() > 0) void'(idQ.pop_front());
      else mErr = 1'b1;
    end
    if (hs) begin
      idQ.push_back(sel);
      mPrio = 1 - sel;
      mLock = -1;
    end else if (expReq && !gnt) begin
      mLock = sel;
    end else if (mLock >= 0 && !req[mLock]) begin
      mLock = -1;
      mErr  = 1'b1;
    end

    @(posedge clk);
    #1;
  endtask

  // Directed scenarios first, then a randomized run with occasional resets.
  initial begin
    logic [1:0] rReq;
    logic       rGnt;
    logic       rRv;
    rst       = 1'b1;
    cReq      = 2'b00;
    apuGnt    = 1'b0;
    apuRvalid = 1'b0;
    cOperands = '0;
    cOp       = '0;
    cFlags    = '0;
    apuRdata  = '0;
    apuRflags = '0;
    modelReset();
    @(posedge clk);
    #1;
    resetDut();

    $display("[TB] alternating grants with back-to-back responses");
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("alt_gnt0", 128'(lastGnt), 128'(2'b01));
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("alt_gnt1", 128'(lastGnt), 128'(2'b10));
    checkOutput("alt_rv1",  128'(lastRvalid), 128'(2'b01));
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("alt_gnt2", 128'(lastGnt), 128'(2'b01));
    checkOutput("alt_rv2",  128'(lastRvalid), 128'(2'b10));
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("alt_gnt3", 128'(lastGnt), 128'(2'b10));
    checkOutput("alt_rv3",  128'(lastRvalid), 128'(2'b01));
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("alt_rv4",  128'(lastRvalid), 128'(2'b10));
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("alt_rv5",  128'(lastRvalid), 128'(2'b01));

    $display("[TB] lock holds core 1 against a later core 0 request");
    resetDut();
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("lock_op0", 128'(lastOp), 128'(drvOp1));
    checkOutput("lock_gnt0", 128'(lastGnt), 128'(2'b00));
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("lock_op1", 128'(lastOp), 128'(drvOp1));
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("lock_op2", 128'(lastOp), 128'(drvOp1));
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("lock_op3", 128'(lastOp), 128'(drvOp1));
    checkOutput("lock_gnt3", 128'(lastGnt), 128'(2'b10));
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("lock_rv", 128'(lastRvalid), 128'(2'b10));

    $display("[TB] full FIFO blocks requests, same-cycle pop does not unblock");
    resetDut();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0);
      checkOutput("fill_gnt", 128'(lastGnt), 128'(2'b01));
    end
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("full_req", 128'(lastReq), 128'(0));
    checkOutput("full_busy", 128'(lastBusy), 128'(1));
    applyStimulus(2'b01, 1'b1, 1'b1);
    checkOutput("full_popgnt", 128'(lastGnt), 128'(2'b00));
    checkOutput("full_poprv", 128'(lastRvalid), 128'(2'b01));
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("full_after", 128'(lastGnt), 128'(2'b01));
    for (int i = 0; i < DEPTH; i++) applyStimulus(2'b00, 1'b0, 1'b1);

    $display("[TB] response with nothing outstanding");
    resetDut();
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("spur_rv", 128'(lastRvalid), 128'(2'b00));
    checkOutput("spur_err0", 128'(lastErr), 128'(0));
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("spur_err1", 128'(lastErr), 128'(1));
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("spur_err2", 128'(lastErr), 128'(1));

    $display("[TB] locked core abandons its request");
    resetDut();
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("drop_req0", 128'(lastReq), 128'(1));
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("drop_req1", 128'(lastReq), 128'(0));
    checkOutput("drop_err1", 128'(lastErr), 128'(0));
    applyStimulus(2'b10, 1'b1, 1'b0);
    checkOutput("drop_gnt", 128'(lastGnt), 128'(2'b10));
    checkOutput("drop_err2", 128'(lastErr), 128'(1));
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("drop_rv", 128'(lastRvalid), 128'(2'b10));

    $display("[TB] reset with operations outstanding");
    resetDut();
    applyStimulus(2'b11, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("mid_busy", 128'(lastBusy), 128'(1));
    checkOutput("mid_clkEn", 128'(lastClkEn), 128'(1));
    resetDut();
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("mid_rv", 128'(lastRvalid), 128'(2'b00));
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("mid_err", 128'(lastErr), 128'(1));

    $display("[TB] randomized traffic");
    resetDut();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) resetDut();
      rReq = 2'($urandom_range(0, 3));
      rGnt = ($urandom_range(0, 3) != 0);
      if (idQ.size() > 0) rRv = 1'($urandom_range(0, 1));
      else rRv = ($urandom_range(0, 39) == 0);
      applyStimulus(rReq, rGnt, rRv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning maximum outstanding FPU operations tracked (power of 2, >=2).
REQ-002 SHALL have parameters APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU, APU_NUSFLAGS_CPU, defaults taken from cv32e40p_apu_core_pkg, meaning APU field widths.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk_i  input  1  clock, all state on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 c_req_i  input  [1:0]  per-core APU request.
REQ-007 c_gnt_o  output  [1:0]  per-core grant.
REQ-008 c_operands_i  input  [1:0][APU_NARGS_CPU-1:0][31:0]  per-core operands.
REQ-009 c_op_i  input  [1:0][APU_WOP_CPU-1:0]  per-core opcode.
REQ-010 c_flags_i  input  [1:0][APU_NDSFLAGS_CPU-1:0]  per-core downstream flags.
REQ-011 c_rvalid_o  output  [1:0]  per-core result valid.
REQ-012 c_rdata_o  output  32  result data, broadcast to both cores.
REQ-013 c_rflags_o  output  APU_NUSFLAGS_CPU  result flags, broadcast.
REQ-014 apu_req_o / apu_gnt_i  output / input  1 / 1  shared FPU request handshake.
REQ-015 apu_operands_o, apu_op_o, apu_flags_o  output  as REQ-008..010 per entry  selected core fields.
REQ-016 apu_rvalid_i, apu_rdata_i, apu_rflags_i  input  1 / 32 / APU_NUSFLAGS_CPU  FPU response.
REQ-017 fpu_clk_en_o  output  1  enable for the FPU clock gate.
REQ-018 busy_o  output  1  any operation outstanding.
REQ-019 err_o  output  1  sticky protocol error.

Function
REQ-020 Arbitration SHALL be round-robin between cores 0 and 1; priority pointer SHALL point to the core not granted at the last accepted handshake.
REQ-021 Selection SHALL be combinational; apu_req_o = (any eligible c_req_i) & !full & !lock-conflict; fields SHALL be muxed from the selected core with zero added latency.
REQ-022 Handshake SHALL be apu_req_o & apu_gnt_i; c_gnt_o[k] SHALL equal apu_gnt_i & apu_req_o & (selected==k); the other bit SHALL be 0.
REQ-023 Lock: if apu_req_o=1 and apu_gnt_i=0, selection SHALL be registered and held on following cycles until handshake, regardless of the other core's request or pointer.
REQ-024 A locked core deasserting c_req_i SHALL clear the lock and set err_o.
REQ-025 ID FIFO (DEPTH entries, 1 bit each) SHALL push the granted core index on every handshake and pop on apu_rvalid_i.
REQ-026 c_rvalid_o[head]=apu_rvalid_i with zero latency; c_rdata_o/c_rflags_o SHALL pass apu_rdata_i/apu_rflags_i through unmodified.
REQ-027 Full (count==DEPTH): apu_req_o SHALL be 0 and lock SHALL NOT form; a same-cycle pop SHALL NOT unblock a push in that cycle.
REQ-028 Simultaneous push and pop when not full: count unchanged, both pointers advance, wrap modulo DEPTH.
REQ-029 apu_rvalid_i with count==0: SHALL be ignored (no c_rvalid_o), err_o set, pointers unchanged.
REQ-030 busy_o = (count!=0); fpu_clk_en_o = |c_req_i | busy_o.
REQ-031 err_o SHALL remain 1 until reset.

Reset
REQ-032 On rst_i assertion, asynchronously: count=0, FIFO pointers=0, priority=core 0, lock cleared, err_o=0; hence apu_req_o, c_gnt_o, c_rvalid_o, busy_o=0 unless c_req_i combinationally active.
REQ-033 Reset mid-operation SHALL discard all outstanding IDs; later apu_rvalid_i SHALL set err_o per REQ-029.

Verification
REQ-034 Both cores request continuously, apu_gnt_i=1, rvalid one cycle later -> grants alternate 0,1,0,1; c_rvalid_o sequence 01,10,01,10 (bit form [1:0]).
REQ-035 Core 1 requests, apu_gnt_i=0 for 3 cycles, core 0 requests from cycle 1 -> apu_op_o stays core 1's for 4 cycles; c_gnt_o=2'b10 on cycle 4.
REQ-036 DEPTH=4, 4 handshakes without rvalid -> apu_req_o=0 at count 4; rvalid+request same cycle -> no grant; next cycle grant.
REQ-037 apu_rvalid_i pulse after reset with no request -> c_rvalid_o=0, err_o=1 next cycle and held.
REQ-038 Locked core 0 drops c_req_i before gnt -> lock cleared, err_o=1, core 1 request granted on next gnt.
REQ-039 rst_i asserted with 2 outstanding -> busy_o=0 and fpu_clk_en_o=0 immediately (no requests active).
